// File: rtl/keypad_coin_scanner.sv
// rtl/keypad_coin_scanner.sv - column-scanned coin keypad with debounce and valid/ready coin event output.
// Optional feature macro: COIN_NICKEL_EN adds the fourth column (4'b1110, nickel, 5 cents) to the scan.
module keypad_coin_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] pad_Row,
  output logic [3:0] pad_Col,
  output logic       coin_valid,
  output logic [6:0] coin_cents,
  input  logic       coin_ready
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;

  localparam logic [23:0] SCAN_LAST = 24'(SCAN_DIV - 1);
  localparam logic [23:0] DEB_LAST  = 24'(DEBOUNCE_CNT - 1);

  state_t      state, state_next;
  logic [23:0] cnt, cnt_next;
  logic [3:0]  col_next;
  logic        valid_next;
  logic [6:0]  cents_next;
  logic        row_low;
  logic        unused_rows;

  // Only row 1 carries coin keys; the other rows are deliberately ignored.
  assign row_low     = ~pad_Row[3];
  assign unused_rows = ^pad_Row[2:0];

  function automatic logic [3:0] next_col(input logic [3:0] c);
    case (c)
      4'b0111: next_col = 4'b1011;
      4'b1011: next_col = 4'b1101;
`ifdef COIN_NICKEL_EN
      4'b1101: next_col = 4'b1110;
      4'b1110: next_col = 4'b0111;
`else
      4'b1101: next_col = 4'b0111;
`endif
      default: next_col = 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] cents_of(input logic [3:0] c);
    case (c)
      4'b0111: cents_of = 7'd100;
      4'b1011: cents_of = 7'd25;
      4'b1101: cents_of = 7'd10;
`ifdef COIN_NICKEL_EN
      4'b1110: cents_of = 7'd5;
`endif
      default: cents_of = 7'd0;
    endcase
  endfunction

  // State, shared counter and all output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SCAN;
      cnt        <= 24'd0;
      pad_Col    <= 4'b0111;
      coin_valid <= 1'b0;
      coin_cents <= 7'd0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      pad_Col    <= col_next;
      coin_valid <= valid_next;
      coin_cents <= cents_next;
    end
  end

  // Next state and counter; the counter restarts on every state change.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 24'd1;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST) begin
          cnt_next = 24'd0;
          if (row_low) state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          state_next = SCAN;
          cnt_next   = 24'd0;
        end else if (cnt == DEB_LAST) begin
          state_next = EMIT;
          cnt_next   = 24'd0;
        end
      end
      EMIT: begin
        cnt_next = 24'd0;
        if (coin_ready) state_next = RELEASE;
      end
      RELEASE: begin
        if (row_low) begin
          cnt_next = 24'd0;
        end else if (cnt == DEB_LAST) begin
          state_next = SCAN;
          cnt_next   = 24'd0;
        end
      end
      default: begin
        state_next = SCAN;
        cnt_next   = 24'd0;
      end
    endcase
  end

  // Next values of the registered outputs: column stepping, coin load and handshake.
  always_comb begin
    col_next   = pad_Col;
    valid_next = coin_valid;
    cents_next = coin_cents;
    case (state)
      SCAN: begin
        if (cnt == SCAN_LAST && !row_low) col_next = next_col(pad_Col);
      end
      DEBOUNCE: begin
        if (!row_low) begin
          col_next = next_col(pad_Col);
        end else if (cnt == DEB_LAST) begin
          valid_next = 1'b1;
          cents_next = cents_of(pad_Col);
        end
      end
      EMIT: begin
        if (coin_ready) valid_next = 1'b0;
      end
      RELEASE: begin
        if (!row_low && cnt == DEB_LAST) col_next = next_col(pad_Col);
      end
      default: begin
        col_next   = 4'b0111;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_coin_scanner.sv
// tb/tb_keypad_coin_scanner.sv - scoreboard bench for keypad_coin_scanner with a physical keypad model.
module tb_keypad_coin_scanner;

  localparam int SD = 4;
  localparam int DC = 3;
`ifdef COIN_NICKEL_EN
  localparam int NCOL = 4;
`else
  localparam int NCOL = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_ready = 1'b1;
  logic       coin_valid;
  logic [6:0] coin_cents;
  logic [3:0] pad_Row;
  logic [3:0] pad_Col;
  logic [3:0] key_col = 4'hF;
  logic [2:0] row_noise = 3'b111;
  bit         rand_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  logic [3:0] col_tab [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  int         cents_tab [4] = '{100, 25, 10, 5};

  // A pressed key pulls row 1 low only while its own column is driven.
  assign pad_Row = {((key_col != 4'hF) && (pad_Col == key_col)) ? 1'b0 : 1'b1, row_noise};

  keypad_coin_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pad_Row    (pad_Row),
    .pad_Col    (pad_Col),
    .coin_valid (coin_valid),
    .coin_cents (coin_cents),
    .coin_ready (coin_ready)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col_entry(input logic [3:0] c);
    logic [3:0] prev;
    bit found;
    found = 0;
    prev = pad_Col;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (pad_Col == c && prev != c) found = 1;
      prev = pad_Col;
    end
    check("wait_col_entry", int'(found), 1);
  endtask

  task automatic wait_valid();
    bit found;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (coin_valid) found = 1;
    end
    check("wait_coin_valid", int'(found), 1);
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Noise on the ignored rows.
  initial forever begin
    @(negedge clk);
    row_noise = 3'($urandom);
  end

  // Random downstream back-pressure when enabled.
  initial forever begin
    @(negedge clk);
    if (rand_ready) coin_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: every accepted coin is popped from the scoreboard and compared.
  initial begin
    logic       pv;
    logic [6:0] pc;
    bit         ph;
    int         e;
    pv = 0; pc = 0; ph = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (ph) check("valid_drop_after_accept", int'(coin_valid), 0);
        if (pv && coin_valid) check("cents_stable", int'(coin_cents), int'(pc));
        ph = 0;
        if (coin_valid && coin_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_coin: got %0d cents expected no event", coin_cents);
          end else begin
            e = exp_q.pop_front();
            check("coin_cents", int'(coin_cents), e);
          end
          ph = 1;
        end
        pv = coin_valid;
        pc = coin_cents;
      end else begin
        pv = 0;
        ph = 0;
      end
    end
  end

  initial begin
    int idx;
    rst_n = 1'b0;
    coin_ready = 1'b1;
    tick(2);
    check("reset_pad_col", int'(pad_Col), 4'b0111);
    check("reset_valid", int'(coin_valid), 0);
    check("reset_cents", int'(coin_cents), 0);
    rst_n = 1'b1;

    // Idle scan: full first dwell, fixed order, never the disabled column.
    for (int k = 0; k < 100; k++) begin
      check("scan_col", int'(pad_Col), int'(col_tab[(k / SD) % NCOL]));
      check("scan_no_valid", int'(coin_valid), 0);
      tick(1);
    end

    // Quarter held 20 cycles; release exit latency and resume column.
    wait_col_entry(4'b1011);
    key_col = 4'b1011;
    exp_q.push_back(25);
    tick(20);
    key_col = 4'hF;
    tick(1);
    check("release_hold_1", int'(pad_Col), 4'b1011);
    tick(1);
    check("release_hold_2", int'(pad_Col), 4'b1011);
    tick(1);
    check("release_resume_col", int'(pad_Col), 4'b1101);
    check("quarter_delivered", exp_q.size(), 0);

    // Two-cycle glitch straddling the last dwell cycle of 0111.
    wait_col_entry(4'b0111);
    tick(2);
    key_col = 4'b0111;
    tick(2);
    key_col = 4'hF;
    tick(1);
    check("glitch_next_col", int'(pad_Col), 4'b1011);
    check("glitch_no_valid", int'(coin_valid), 0);
    tick(10);

    // Dime held pending by back-pressure, key released during the wait.
    coin_ready = 1'b0;
    wait_col_entry(4'b1101);
    key_col = 4'b1101;
    exp_q.push_back(10);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      check("dime_pending_valid", int'(coin_valid), 1);
      check("dime_pending_cents", int'(coin_cents), 10);
      if (i == 3) key_col = 4'hF;
      tick(1);
    end
    coin_ready = 1'b1;
    tick(1);
    check("dime_valid_dropped", int'(coin_valid), 0);
    check("dime_delivered", exp_q.size(), 0);
    tick(DC + 3);

    // Reset while a dollar is pending: event dropped.
    coin_ready = 1'b0;
    wait_col_entry(4'b0111);
    key_col = 4'b0111;
    wait_valid();
    check("dollar_cents", int'(coin_cents), 100);
    rst_n = 1'b0;
    key_col = 4'hF;
    tick(1);
    rst_n = 1'b1;
    check("midreset_valid", int'(coin_valid), 0);
    check("midreset_cents", int'(coin_cents), 0);
    check("midreset_col", int'(pad_Col), 4'b0111);
    coin_ready = 1'b1;
    tick(30);

`ifdef COIN_NICKEL_EN
    wait_col_entry(4'b1110);
    key_col = 4'b1110;
    exp_q.push_back(5);
    tick(15);
    key_col = 4'hF;
    wait_drain(200);
    tick(DC + 2);
`endif

    // Random presses and glitches under random back-pressure.
    rand_ready = 1'b1;
    repeat (16) begin
      idx = $urandom_range(0, NCOL - 1);
      tick($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) begin
        key_col = col_tab[idx];
        tick($urandom_range(1, DC));
        key_col = 4'hF;
        tick(DC + 2);
      end else begin
        exp_q.push_back(cents_tab[idx]);
        key_col = col_tab[idx];
        tick(NCOL * SD + DC + 2 + $urandom_range(0, 20));
        key_col = 4'hF;
        wait_drain(500);
        tick(DC + 2);
      end
    end
    rand_ready = 1'b0;
    coin_ready = 1'b1;
    tick(5);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_coin_scanner.md
KEYPAD_COIN_SCANNER -- requirements
Module: keypad_coin_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each column is driven (1 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 500000, consecutive clk cycles a key level must be stable (10 ms); legal range 2..2^24-1.
REQ-003 clk  input  1  single system clock, rising-edge; sole clock of the block.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 pad_Row  input  4  keypad rows, active-low; only bit 3 (row 1) is used; bits 2:0 ignored.
REQ-006 pad_Col  output  4  keypad column drive, active-low one-hot, registered.
REQ-007 coin_valid  output  1  coin event available, registered.
REQ-008 coin_cents  output  7  coin value in cents (5/10/25/100), registered, stable while coin_valid=1.
REQ-009 coin_ready  input  1  downstream vending machine accepts the coin event this cycle.

Function
REQ-010 Column map: 4'b0111 = dollar (100), 4'b1011 = quarter (25), 4'b1101 = dime (10), 4'b1110 = nickel (5, only per REQ-026).
REQ-011 States SHALL be SCAN, DEBOUNCE, EMIT, RELEASE; one 24-bit cycle counter shared by all states, cleared on every state change.
REQ-012 SCAN: drive current column for SCAN_DIV cycles; on the last dwell cycle, if pad_Row[3]=0 -> DEBOUNCE with column frozen, else advance to next column, counter cleared.
REQ-013 Column order 0111 -> 1011 -> 1101 -> 0111 (wrap); pad_Col changes exactly once per SCAN_DIV cycles while in SCAN.
REQ-014 DEBOUNCE: any cycle with pad_Row[3]=1 -> SCAN, advance to next column; DEBOUNCE_CNT consecutive low cycles -> EMIT.
REQ-015 On entry to EMIT, coin_cents SHALL be loaded from the frozen column and coin_valid SHALL assert the cycle after the final debounce cycle.
REQ-016 EMIT: coin_valid held 1 and coin_cents held constant until the cycle with coin_valid=1 and coin_ready=1; next cycle coin_valid=0, state RELEASE.
REQ-017 coin_ready while coin_valid=0 SHALL have no effect; exactly one coin event per key press regardless of hold duration.
REQ-018 RELEASE: column stays frozen; DEBOUNCE_CNT consecutive cycles of pad_Row[3]=1 -> SCAN, advance to next column; any low cycle restarts the count.
REQ-019 Key held indefinitely SHALL leave the block in RELEASE with coin_valid=0; no repeat events.
REQ-020 Key released during EMIT SHALL NOT withdraw coin_valid; the event completes per REQ-016.
REQ-021 coin_cents SHALL keep its last value when coin_valid=0.

Reset
REQ-022 With rst_n=0 at a rising clk edge: state SCAN, counter 0, pad_Col=4'b0111, coin_valid=0, coin_cents=0.
REQ-023 Reset mid-operation (any state, including EMIT with coin pending) SHALL drop the pending event with no coin delivered.
REQ-024 First SCAN dwell after reset release SHALL last the full SCAN_DIV cycles.
REQ-025 All outputs SHALL be driven from flops; no combinational path from pad_Row or coin_ready to any output.

Configuration
REQ-026 Macro COIN_NICKEL_EN defined: fourth column 4'b1110 = nickel (5); scan order 0111 -> 1011 -> 1101 -> 1110 -> 0111.
REQ-027 COIN_NICKEL_EN undefined: column 4'b1110 SHALL never be driven, no value 5 generated; behaviour per REQ-013.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, coin_ready=1 unless stated)
REQ-028 Reset, no keys: pad_Col sequence 0111,1011,1101,0111 each held 4 cycles; coin_valid stays 0.
REQ-029 Hold row 1 low during column 1011 for 20 cycles, then release -> one coin_valid pulse, coin_cents=25; RELEASE exits 3 cycles after release; scan resumes at 1101.
REQ-030 coin_ready=0 for 10 cycles after dime detect -> coin_valid=1, coin_cents=10 held 10 cycles; drops 1 cycle after coin_ready=1.
REQ-031 Row 1 low for 2 cycles only (glitch) on column 0111 -> no coin_valid; scan continues at 1011.
REQ-032 rst_n=0 for 1 cycle while coin_valid=1 (dollar pending) -> next cycle coin_valid=0, coin_cents=0, pad_Col=0111.
REQ-033 With COIN_NICKEL_EN: press on column 1110 -> coin_cents=5; without it, 1110 never observed on pad_Col over 100 cycles.
